gate_truth_checker: RTL and testbench



---
 rtl/gate_check_pkg.sv | 20 ++
 rtl/gate_check_if.sv | 27 ++
 rtl/gate_truth_checker.sv | 118 +++++++++++
 tb/tb_gate_truth_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Optional build macro: GATE_CHECK_STOP_ON_FAIL_EN.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int IDX_W = 2;
    localparam int CNT_W = 4;

endpackage

// File: rtl/gate_check_if.sv
// Signal bundle between the checker and the gate/controller around it.
// master = checker side, slave = environment side.
interface gate_check_if;

    logic       start;
    logic       y_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        input  start, y_in,
        output a_out, b_out, busy, done,
        output pass, err_count, fail_vec
    );

    modport slave (
        output start, y_in,
        input  a_out, b_out, busy, done,
        input  pass, err_count, fail_vec
    );

endinterface

// File: rtl/gate_truth_checker.sv
// Drives all {a,b} patterns into a 2-input gate and checks y against TT.
// Define GATE_CHECK_STOP_ON_FAIL_EN to end a run at the first mismatch.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter logic [3:0] TT     = TT_NOR,
    parameter int         SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    gate_check_if.master io
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         fail_q, fail_d;
    logic [2:0]         err_q, err_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               mism;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        err_d   = err_q;
        pass_d  = pass_q;
        mism    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    fail_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(SETTLE)) begin
                    mism  = (io.y_in != TT[idx_q]);
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (mism) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                    if (mism) begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // pass is settled on entry to DONE so it is visible with done
        if (state_q == RUN && state_d == DONE) begin
            pass_d = (err_d == 3'd0);
            idx_d  = '0;
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        a_d    = busy_d & idx_d[1];
        b_d    = busy_d & idx_d[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign io.a_out     = a_q;
    assign io.b_out     = b_q;
    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.pass      = pass_q;
    assign io.err_count = err_q;
    assign io.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: random gate behaviours against a truth-table model.
// Honours GATE_CHECK_STOP_ON_FAIL_EN in its expectations.
module tb_gate_truth_checker;
    import gate_check_pkg::*;

    localparam logic [3:0] TT = TT_NOR;
    localparam int         S  = 3;

    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       ps;
        int         at;
        int         np;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gate_tt;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    exp_t       sb[$];
    exp_t       last;
    logic [1:0] plog[$];

    gate_check_if io();

    assign io.y_in = gate_tt[{io.a_out, io.b_out}];

    gate_truth_checker #(.TT(TT), .SETTLE(S)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic exp_t model(logic [3:0] g, int c0);
        exp_t e;
        logic [3:0] f;
        f    = g ^ TT;
        e.np = 4;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        for (int i = 3; i >= 0; i--) if (f[i]) e.np = i + 1;
        if (f != 4'd0) f = 4'd1 << (e.np - 1);
`endif
        e.fv = f;
        e.ec = 3'($countones(f));
        e.ps = (f == 4'd0);
        e.at = c0 + e.np * (S + 1);
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        bit   ok;
        if (rst) begin
            plog.delete();
        end else begin
            if (io.busy) plog.push_back({io.a_out, io.b_out});
            if (io.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.at);
                    chk("fail_vec", io.fail_vec, e.fv);
                    chk("err_count", io.err_count, e.ec);
                    chk("pass", io.pass, e.ps);
                    chk("busy_in_done", io.busy, 0);
                    ok = (plog.size() == e.np * (S + 1));
                    for (int i = 0; i < plog.size(); i++)
                        if (plog[i] != 2'(i / (S + 1))) ok = 0;
                    chk("pattern_seq", ok, 1);
                end
                plog.delete();
            end
        end
    end

    task automatic run(logic [3:0] g, bit pokes);
        int   c0;
        exp_t e;
        @(negedge clk);
        gate_tt  = g;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        c0 = cyc;
        e  = model(g, c0);
        sb.push_back(e);
        last = e;
        if (pokes) begin
            while (cyc < e.at) begin
                @(negedge clk);
                io.start = (cyc == e.at) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            io.start = 1'b0;
        end
        while (cyc < e.at + 2) @(negedge clk);
    endtask

    task automatic held(logic [3:0] g);
        exp_t e1, e2;
        @(negedge clk);
        gate_tt  = g;
        io.start = 1'b1;
        @(negedge clk);
        e1 = model(g, cyc);
        e2 = model(g, e1.at + 2);
        sb.push_back(e1);
        sb.push_back(e2);
        last = e2;
        while (cyc < e1.at + 2) @(negedge clk);
        io.start = 1'b0;
        while (cyc < e2.at + 2) @(negedge clk);
    endtask

    task automatic reset_vals(string nm);
        chk({nm, "_busy"}, io.busy, 0);
        chk({nm, "_done"}, io.done, 0);
        chk({nm, "_ab"}, {io.a_out, io.b_out}, 0);
        chk({nm, "_pass"}, io.pass, 0);
        chk({nm, "_err"}, io.err_count, 0);
        chk({nm, "_fv"}, io.fail_vec, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        io.start = 1'b0;
        gate_tt  = TT;
        repeat (2) @(negedge clk);
        #1 reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;

        run(TT, 0);
        run(TT_NAND, 0);
        run(4'b0000, 0);
        run(TT_XOR, 1);
        run(TT_OR, 0);
        held(TT_AND);
        held(TT);

        @(negedge clk);
        gate_tt  = TT;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_busy", io.busy, 1);
        rst = 1'b1;
        #1 reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_pending", sb.size(), 0);
        run(TT_NAND, 0);

        repeat (8) run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        run(TT_XOR, 0);
        repeat (20) begin
            @(negedge clk);
            gate_tt = 4'($urandom_range(0, 15));
            chk("hold_fv", io.fail_vec, last.fv);
            chk("hold_err", io.err_count, last.ec);
            chk("hold_pass", io.pass, last.ps);
        end

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
